// File: rtl/var_state_seq_if.sv
// Host command handshake and bin state-memory port of the variable-state sequencer.
// The sequencer connects through the slave modport; the host/memory side uses master.
interface var_state_seq_if #(
  parameter int WIDTH_VAR_IDX    = 3,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19
);
  logic                        cmd_valid_i;
  logic [2:0]                  cmd_i;
  logic [WIDTH_LVL-1:0]        cmd_lvl_i;
  logic                        cmd_ready_o;
  logic                        done_o;
  logic [2:0]                  status_o;
  logic [WIDTH_LVL-1:0]        lvl_o;
  logic                        mem_rd_en_o;
  logic                        mem_wr_en_o;
  logic [WIDTH_VAR_IDX-1:0]    mem_addr_o;
  logic [WIDTH_VAR_STATES-1:0] mem_rdata_i;
  logic [WIDTH_VAR_STATES-1:0] mem_wdata_o;

  modport slave (
    input  cmd_valid_i, cmd_i, cmd_lvl_i, mem_rdata_i,
    output cmd_ready_o, done_o, status_o, lvl_o,
           mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cmd_valid_i, cmd_i, cmd_lvl_i, mem_rdata_i,
    input  cmd_ready_o, done_o, status_o, lvl_o,
           mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/var_state_seq.sv
// Sequencer for the Sat Engine variable-state array: runs one host command at a
// time (LOAD, IMPLY, ANALYZE, BKT, STORE) and owns the array's write/apply inputs
// and the bin state-memory port.
module var_state_seq #(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_IDX    = 3,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int MAX_IMPLY_ROUNDS = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  var_state_seq_if.slave                       bus,
  output logic [NUM_VARS-1:0]                  wr_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
  output logic                                 apply_imply_o,
  output logic                                 apply_analyze_o,
  output logic                                 apply_bkt_o,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  input  logic [NUM_VARS-1:0]                  find_imply_i,
  input  logic [NUM_VARS-1:0]                  find_conflict_i,
  input  logic [WIDTH_LVL-1:0]                 max_lvl_i
);

  localparam int IDX_W = WIDTH_VAR_IDX + 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VARS - 1);
  localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_VARS);
  localparam logic [7:0]       ROUND_MAX = 8'(MAX_IMPLY_ROUNDS);

  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_IMPLY   = 3'd2;
  localparam logic [2:0] CMD_ANALYZE = 3'd3;
  localparam logic [2:0] CMD_BKT     = 3'd4;
  localparam logic [2:0] CMD_STORE   = 3'd5;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_CONFLICT  = 3'd1;
  localparam logic [2:0] ST_QUIESCENT = 3'd2;
  localparam logic [2:0] ST_TIMEOUT   = 3'd3;
  localparam logic [2:0] ST_ILLEGAL   = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_IMPLY_APPLY, S_IMPLY_WAIT, S_ANALYZE_APPLY,
    S_ANALYZE_CAP, S_BKT, S_STORE, S_FIN
  } state_t;

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            idx;
  logic [7:0]                  round;
  logic [2:0]                  status_r;
  logic [WIDTH_LVL-1:0]        lvl_r;
  logic [WIDTH_LVL-1:0]        bkt_lvl_r;
  logic                        cmd_ready, accept;
  logic                        imply_end;
  logic [2:0]                  imply_status;
  logic                        rd_en, wr_en;
  logic [WIDTH_VAR_IDX-1:0]    addr;
  logic                        rd_vld_p1;
  logic [WIDTH_VAR_IDX-1:0]    rd_idx_p1;
  logic [WIDTH_VAR_STATES-1:0] slot_in [NUM_VARS];

  function automatic state_t cmd_target(input logic [2:0] cmd);
    case (cmd)
      CMD_LOAD:    return S_LOAD;
      CMD_IMPLY:   return S_IMPLY_APPLY;
      CMD_ANALYZE: return S_ANALYZE_APPLY;
      CMD_BKT:     return S_BKT;
      CMD_STORE:   return S_STORE;
      default:     return S_FIN;
    endcase
  endfunction

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return (cmd >= CMD_LOAD) && (cmd <= CMD_STORE);
  endfunction

  for (genvar g = 0; g < NUM_VARS; g++) begin : g_slot
    assign slot_in[g] = vars_states_i[g*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
  end

  // The done cycles (FIN, ANALYZE_CAP) accept a new command just like IDLE.
  assign cmd_ready = (state == S_IDLE) || (state == S_FIN) || (state == S_ANALYZE_CAP);
  assign accept    = bus.cmd_valid_i && cmd_ready;

  // Next-state selection and implication round verdict.
  always_comb begin
    state_nxt    = state;
    imply_end    = 1'b0;
    imply_status = ST_OK;
    case (state)
      S_LOAD:          if (idx == IDX_END) state_nxt = S_FIN;
      S_IMPLY_APPLY:   state_nxt = S_IMPLY_WAIT;
      S_IMPLY_WAIT: begin
        imply_end = 1'b1;
        state_nxt = S_FIN;
        if (|find_conflict_i)                imply_status = ST_CONFLICT;
        else if (~|find_imply_i)             imply_status = ST_QUIESCENT;
        else if ((round + 8'd1) == ROUND_MAX) imply_status = ST_TIMEOUT;
        else begin
          imply_end = 1'b0;
          state_nxt = S_IMPLY_APPLY;
        end
      end
      S_ANALYZE_APPLY: state_nxt = S_ANALYZE_CAP;
      S_ANALYZE_CAP:   state_nxt = S_IDLE;
      S_BKT:           state_nxt = S_FIN;
      S_STORE:         if (idx == IDX_LAST) state_nxt = S_FIN;
      S_FIN:           state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
    if (accept) state_nxt = cmd_target(bus.cmd_i);
  end

  // State, counters and held results; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      round     <= '0;
      status_r  <= ST_OK;
      lvl_r     <= '0;
      bkt_lvl_r <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= rd_en;
      if (accept) begin
        idx      <= '0;
        round    <= '0;
        status_r <= cmd_legal(bus.cmd_i) ? ST_OK : ST_ILLEGAL;
        if (bus.cmd_i == CMD_BKT) bkt_lvl_r <= bus.cmd_lvl_i;
      end else begin
        if ((state == S_LOAD) || (state == S_STORE)) idx <= idx + 1'b1;
        if (state == S_IMPLY_WAIT) begin
          if (imply_end) status_r <= imply_status;
          else           round    <= round + 8'd1;
        end
      end
      if (state == S_ANALYZE_CAP) lvl_r <= max_lvl_i;
    end
  end

  // Stage p0 -> p1: the slot index follows its read so the write lines up with mem_rdata_i.
  always_ff @(posedge clk) begin
    rd_idx_p1 <= addr;
  end

  // The index reaches NUM_VARS in LOAD only to drain the final read, so its MSB stops reads.
  assign rd_en = (state == S_LOAD) && !idx[WIDTH_VAR_IDX];
  assign wr_en = (state == S_STORE);
  assign addr  = (rd_en || wr_en) ? idx[WIDTH_VAR_IDX-1:0] : '0;

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.done_o      = (state == S_FIN) || (state == S_ANALYZE_CAP);
  assign bus.status_o    = status_r;
  assign bus.lvl_o       = lvl_r;
  assign bus.mem_rd_en_o = rd_en;
  assign bus.mem_wr_en_o = wr_en;
  assign bus.mem_addr_o  = addr;
  assign bus.mem_wdata_o = wr_en ? slot_in[addr] : '0;

  assign wr_states_o     = rd_vld_p1 ? ({{(NUM_VARS-1){1'b0}}, 1'b1} << rd_idx_p1) : '0;
  assign vars_states_o   = rd_vld_p1 ? {NUM_VARS{bus.mem_rdata_i}} : '0;
  assign apply_imply_o   = (state == S_IMPLY_APPLY);
  assign apply_analyze_o = (state == S_ANALYZE_APPLY);
  assign apply_bkt_o     = (state == S_BKT);
  assign bkt_lvl_o       = bkt_lvl_r;

endmodule

// File: tb/tb_var_state_seq.sv
// Bench for var_state_seq: directed command table, hand-written corner sequences
// and randomized commands checked against a sample-level reference model.
module tb_var_state_seq;
  localparam int NV = 8, IW = 3, LW = 16, SW = 19, MAXR = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  var_state_seq_if #(.WIDTH_VAR_IDX(IW), .WIDTH_LVL(LW), .WIDTH_VAR_STATES(SW)) bus();

  logic [NV-1:0]    wr_states, find_imply, find_conflict;
  logic [SW*NV-1:0] vs_o, vs_i;
  logic             ai, aa, ab;
  logic [LW-1:0]    bkt_lvl, max_lvl;

  var_state_seq #(.NUM_VARS(NV), .WIDTH_VAR_IDX(IW), .WIDTH_LVL(LW),
                  .WIDTH_VAR_STATES(SW), .MAX_IMPLY_ROUNDS(MAXR)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wr_states_o(wr_states), .vars_states_o(vs_o), .vars_states_i(vs_i),
    .apply_imply_o(ai), .apply_analyze_o(aa), .apply_bkt_o(ab),
    .bkt_lvl_o(bkt_lvl), .find_imply_i(find_imply), .find_conflict_i(find_conflict),
    .max_lvl_i(max_lvl)
  );

  typedef struct {
    logic [2:0]    cmd;
    logic [LW-1:0] lvl;
    logic [LW-1:0] maxl;
    int            imp_len;   // number of samples that still report implications
    int            conf_at;   // sample number that reports a conflict (0 = never)
    logic [NV-1:0] imp_pat;
    bit            noise;     // drive junk commands while busy
    logic [2:0]    exp_status;
    int            exp_lat;
    int            exp_imply;
    logic [LW-1:0] exp_lvl;
    logic [LW-1:0] exp_bkt;
  } vec_t;

  typedef struct {
    int            lat;
    logic [NV-1:0] ws;
    logic [SW-1:0] d;
  } ld_t;

  int n_cmp = 0, n_fail = 0;
  logic [SW-1:0]    mem       [NV];
  logic [SW-1:0]    slot_m    [NV];
  logic [SW-1:0]    exp_slots [NV];
  logic [IW+SW-1:0] wr_q [$];
  logic [LW-1:0]    mlvl, mbkt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory with one-cycle read latency, array slot storage and memory write log.
  always @(posedge clk) begin
    if (bus.mem_rd_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    for (int k = 0; k < NV; k++)
      if (wr_states[k]) slot_m[k] <= vs_o[k*SW +: SW];
    if (bus.mem_wr_en_o) wr_q.push_back({bus.mem_addr_o, bus.mem_wdata_o});
  end

  always_comb begin
    vs_i = '0;
    for (int k = 0; k < NV; k++) vs_i[k*SW +: SW] = slot_m[k];
  end

  // Strobe exclusivity: only the LOAD read/write overlap is allowed.
  always @(negedge clk) begin : excl_mon
    int others;
    if (!rst) begin
      others = int'(ai) + int'(aa) + int'(ab) + int'(bus.mem_wr_en_o);
      chk("strobe_excl", (others > 1) || (others == 1 && (bus.mem_rd_en_o || (|wr_states))), 1'b0);
    end
  end

  // Reference: walk the implication samples in order and stop at the first rule hit.
  function automatic void ref_imply(input int il, input int ca, output logic [2:0] st, output int np);
    st = 3'd3; np = MAXR;
    for (int s = 1; s <= MAXR; s++) begin
      if (s == ca)   begin st = 3'd1; np = s; return; end
      if (s > il)    begin st = 3'd2; np = s; return; end
      if (s == MAXR) begin st = 3'd3; np = s; return; end
    end
  endfunction

  function automatic int ref_lat(input logic [2:0] c, input int np);
    case (c)
      3'd1:      return NV + 2;
      3'd2:      return 2 * np + 1;
      3'd3, 3'd4: return 2;
      3'd5:      return NV + 1;
      default:   return 1;
    endcase
  endfunction

  task automatic run(input vec_t v, input string nm);
    int lat, ni, na, nb, nrd, k;
    bit seen;
    logic [LW-1:0] bk_seen;
    ld_t ld[$];
    ld_t e;
    wr_q.delete();
    find_imply = '0; find_conflict = '0; max_lvl = v.maxl;
    lat = 0;
    while (!bus.cmd_ready_o && lat < 100) begin @(negedge clk); lat++; end
    chk({nm, "_ready_in"}, bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1; bus.cmd_i = v.cmd; bus.cmd_lvl_i = v.lvl;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    lat = 1; ni = 0; na = 0; nb = 0; nrd = 0; seen = 0; bk_seen = '0;
    if (v.exp_lat > 1) chk({nm, "_busy"}, bus.cmd_ready_o, 1'b0);
    while (lat < 200) begin
      if (ai) begin
        ni++;
        find_imply    = (ni <= v.imp_len) ? v.imp_pat : '0;
        find_conflict = (ni == v.conf_at) ? 8'h10 : '0;
      end
      if (aa) na++;
      if (ab) begin nb++; bk_seen = bkt_lvl; end
      if (bus.mem_rd_en_o) nrd++;
      if (|wr_states) begin
        e.lat = lat; e.ws = wr_states; e.d = '0;
        for (int j = 0; j < NV; j++) if (wr_states[j]) e.d = vs_o[j*SW +: SW];
        ld.push_back(e);
      end
      if (bus.done_o) begin seen = 1; break; end
      if (v.noise) begin
        bus.cmd_valid_i = 1'b1; bus.cmd_i = 3'($urandom_range(0, 7)); bus.cmd_lvl_i = 16'($urandom);
      end
      @(negedge clk); lat++;
    end
    bus.cmd_valid_i = 1'b0;
    chk({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_status"}, bus.status_o, v.exp_status);
    chk({nm, "_imply_pulses"}, ni, v.exp_imply);
    chk({nm, "_analyze_pulses"}, na, (v.cmd == 3'd3) ? 1 : 0);
    chk({nm, "_bkt_pulses"}, nb, (v.cmd == 3'd4) ? 1 : 0);
    chk({nm, "_mem_reads"}, nrd, (v.cmd == 3'd1) ? NV : 0);
    chk({nm, "_slot_writes"}, ld.size(), (v.cmd == 3'd1) ? NV : 0);
    chk({nm, "_mem_writes"}, wr_q.size(), (v.cmd == 3'd5) ? NV : 0);
    if (v.cmd == 3'd1 && ld.size() == NV)
      for (k = 0; k < NV; k++) begin
        chk($sformatf("%s_ld%0d_ws", nm, k), ld[k].ws, 64'(1) << k);
        chk($sformatf("%s_ld%0d_data", nm, k), ld[k].d, mem[k]);
        chk($sformatf("%s_ld%0d_cycle", nm, k), ld[k].lat, k + 2);
      end
    if (v.cmd == 3'd5 && wr_q.size() == NV)
      for (k = 0; k < NV; k++)
        chk($sformatf("%s_st%0d", nm, k), wr_q[k], {IW'(k), exp_slots[k]});
    if (v.cmd == 3'd4) chk({nm, "_bkt_lvl_at_pulse"}, bk_seen, v.lvl);
    @(negedge clk);
    chk({nm, "_ready_after"}, bus.cmd_ready_o, 1'b1);
    chk({nm, "_done_once"}, bus.done_o, 1'b0);
    chk({nm, "_status_held"}, bus.status_o, v.exp_status);
    chk({nm, "_lvl_o"}, bus.lvl_o, v.exp_lvl);
    chk({nm, "_bkt_lvl_o"}, bkt_lvl, v.exp_bkt);
  endtask

  initial begin
    vec_t tbl [12];
    vec_t v;
    logic [2:0] st;
    int np, cnt;

    bus.cmd_valid_i = 1'b0; bus.cmd_i = '0; bus.cmd_lvl_i = '0;
    find_imply = '0; find_conflict = '0; max_lvl = '0;
    for (int k = 0; k < NV; k++) begin
      mem[k] = 19'h100 + 19'(k); slot_m[k] = '0; exp_slots[k] = '0;
    end

    // cmd lvl maxl imp_len conf_at imp_pat noise | status lat imply lvl bkt
    tbl[0]  = '{3'd1, 16'd0, 16'd0,  0,  0, 8'h00, 1'b0, 3'd0, 10,  0, 16'd0, 16'd0};
    tbl[1]  = '{3'd2, 16'd0, 16'd0,  2,  0, 8'h04, 1'b0, 3'd2,  7,  3, 16'd0, 16'd0};
    tbl[2]  = '{3'd2, 16'd0, 16'd0, 99,  1, 8'h01, 1'b0, 3'd1,  3,  1, 16'd0, 16'd0};
    tbl[3]  = '{3'd2, 16'd0, 16'd0, 99,  0, 8'h01, 1'b0, 3'd3, 31, 15, 16'd0, 16'd0};
    tbl[4]  = '{3'd3, 16'd0, 16'd7,  0,  0, 8'h00, 1'b0, 3'd0,  2,  0, 16'd7, 16'd0};
    tbl[5]  = '{3'd4, 16'd3, 16'd0,  0,  0, 8'h00, 1'b0, 3'd0,  2,  0, 16'd7, 16'd3};
    tbl[6]  = '{3'd5, 16'd0, 16'd0,  0,  0, 8'h00, 1'b0, 3'd0,  9,  0, 16'd7, 16'd3};
    tbl[7]  = '{3'd0, 16'd0, 16'd0,  0,  0, 8'h00, 1'b0, 3'd4,  1,  0, 16'd7, 16'd3};
    tbl[8]  = '{3'd7, 16'd9, 16'd0,  0,  0, 8'h00, 1'b0, 3'd4,  1,  0, 16'd7, 16'd3};
    tbl[9]  = '{3'd2, 16'd0, 16'd0,  0,  0, 8'h04, 1'b0, 3'd2,  3,  1, 16'd7, 16'd3};
    tbl[10] = '{3'd2, 16'd0, 16'd0, 14,  0, 8'h80, 1'b0, 3'd2, 31, 15, 16'd7, 16'd3};
    tbl[11] = '{3'd2, 16'd0, 16'd0, 99, 15, 8'h02, 1'b0, 3'd1, 31, 15, 16'd7, 16'd3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cmd_ready_o, 1'b1);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_status", bus.status_o, 3'd0);
    chk("rst_lvl", bus.lvl_o, 16'd0);
    chk("rst_bkt_lvl", bkt_lvl, 16'd0);
    chk("rst_strobes", {ai, aa, ab, bus.mem_rd_en_o, bus.mem_wr_en_o}, 5'd0);
    chk("rst_wr_states", wr_states, 8'd0);
    chk("rst_vars_states", vs_o, '0);
    chk("rst_mem_addr_wdata", {bus.mem_addr_o, bus.mem_wdata_o}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run(tbl[i], $sformatf("tbl%0d", i));
      if (tbl[i].cmd == 3'd1) for (int k = 0; k < NV; k++) exp_slots[k] = mem[k];
    end
    mlvl = 16'd7; mbkt = 16'd3;

    // New command accepted in the done cycle of the previous one
    bus.cmd_valid_i = 1'b1; bus.cmd_i = 3'd4; bus.cmd_lvl_i = 16'h0055;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("b2b_bkt_pulse", ab, 1'b1);
    @(negedge clk);
    chk("b2b_done1", bus.done_o, 1'b1);
    chk("b2b_ready_in_done", bus.cmd_ready_o, 1'b1);
    bus.cmd_valid_i = 1'b1; bus.cmd_i = 3'd6;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("b2b_done2", bus.done_o, 1'b1);
    chk("b2b_status_illegal", bus.status_o, 3'd4);
    chk("b2b_bkt_lvl", bkt_lvl, 16'h0055);
    @(negedge clk);
    chk("b2b_idle", bus.done_o, 1'b0);
    mbkt = 16'h0055;

    // Randomized commands against the reference model
    for (int i = 0; i < 60; i++) begin
      v.cmd = 3'($urandom_range(0, 7));
      v.lvl = 16'($urandom); v.maxl = 16'($urandom);
      v.imp_len = $urandom_range(0, 18); v.conf_at = $urandom_range(0, 18);
      v.imp_pat = 8'($urandom_range(1, 255)); v.noise = 1'($urandom);
      if (v.cmd == 3'd1) for (int k = 0; k < NV; k++) mem[k] = 19'($urandom);
      np = 0; st = 3'd0;
      if (v.cmd == 3'd2) ref_imply(v.imp_len, v.conf_at, st, np);
      else if (v.cmd == 3'd0 || v.cmd > 3'd5) st = 3'd4;
      if (v.cmd == 3'd3) mlvl = v.maxl;
      if (v.cmd == 3'd4) mbkt = v.lvl;
      v.exp_status = st; v.exp_imply = np; v.exp_lat = ref_lat(v.cmd, np);
      v.exp_lvl = mlvl; v.exp_bkt = mbkt;
      run(v, $sformatf("rnd%0d", i));
      if (v.cmd == 3'd1) for (int k = 0; k < NV; k++) exp_slots[k] = mem[k];
    end

    // Reset in the middle of STORE
    wr_q.delete();
    bus.cmd_valid_i = 1'b1; bus.cmd_i = 3'd5;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    cnt = 0;
    while (!(bus.mem_wr_en_o && bus.mem_addr_o == 3'd4) && cnt < 20) begin @(negedge clk); cnt++; end
    chk("rstmid_reached_write4", bus.mem_addr_o, 3'd4);
    rst = 1'b1;
    #1;
    chk("rstmid_wr_en_drop", bus.mem_wr_en_o, 1'b0);
    chk("rstmid_ready", bus.cmd_ready_o, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_wr_en_o || ai || aa || ab || bus.mem_rd_en_o) cnt++;
    end
    chk("rstmid_no_strobes_after", cnt, 0);
    chk("rstmid_writes_before", wr_q.size(), 4);
    chk("rstmid_ready_after", bus.cmd_ready_o, 1'b1);
    chk("rstmid_status_clr", bus.status_o, 3'd0);
    chk("rstmid_bkt_clr", bkt_lvl, 16'd0);

    // Recovery: LOAD then STORE round-trip
    for (int k = 0; k < NV; k++) mem[k] = 19'h4_0000 + 19'(k * 3);
    v = '{3'd1, 16'd0, 16'd0, 0, 0, 8'h00, 1'b1, 3'd0, 10, 0, 16'd0, 16'd0};
    run(v, "post_rst_load");
    for (int k = 0; k < NV; k++) exp_slots[k] = mem[k];
    v.cmd = 3'd5; v.exp_lat = 9;
    run(v, "post_rst_store");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
